// File: rtl/mcycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mcycle_ctrl_pkg
//  Brief  : Shared opcode/funct constants, default halt address and the
//           sequencer state encoding for the multi-cycle controller.
//  Rev    : 1.0  initial release
// ============================================================================
package mcycle_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SLT   = 6'd42;

    // Program end: execution halts once pc reaches this address
    localparam int DEFAULT_MAX_PC = 14;

    // Nine sequencer states need four bits
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_CHECK  = 4'd6,
        ST_PAUSE  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

endpackage : mcycle_ctrl_pkg
`default_nettype wire

// File: rtl/mcycle_ctrl_insn_class.sv
`default_nettype none
// ============================================================================
//  Module : insn_class
//  Brief  : Combinational instruction classifier: opcode/funct -> legal,
//           uses_mem (load) and writes_reg (register-file destination).
//  Rev    : 1.0  initial release
// ============================================================================
module insn_class
    import mcycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal,
    output logic       uses_mem,
    output logic       writes_reg
);

    // Decode the supported subset; funct only matters for R-type
    always_comb begin
        legal      = 1'b0;
        uses_mem   = 1'b0;
        writes_reg = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SLT: begin
                        legal      = 1'b1;
                        writes_reg = 1'b1;
                    end
                    FN_JR:   legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            // jal's link write is folded into the pc update by the datapath
            OP_JAL, OP_BEQ, OP_BNE: legal = 1'b1;
            OP_ADDIU: begin
                legal      = 1'b1;
                writes_reg = 1'b1;
            end
            OP_LW: begin
                legal      = 1'b1;
                uses_mem   = 1'b1;
                writes_reg = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule : insn_class
`default_nettype wire

// File: rtl/mcycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : mcycle_ctrl
//  Brief  : Multi-cycle sequencer for the 8-bit MIPS-subset datapath.
//           Walks each instruction through FETCH/DECODE/EXEC/MEM/WB/CHECK,
//           handshakes with instruction and data memory, gates datapath
//           enables, counts retired instructions and halts at program end.
//  Rev    : 1.0  initial release
// ============================================================================
module mcycle_ctrl
    import mcycle_ctrl_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int MAX_PC = DEFAULT_MAX_PC,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [PC_W-1:0]  pc,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dec_en,
    output logic             exe_en,
    output logic             pc_we,
    output logic             dmem_req,
    output logic             wb_en,
    output logic             out_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    // One extra bit so a MAX_PC of 2**PC_W never truncates to zero
    localparam logic [PC_W:0] C_MAX_PC = (PC_W+1)'(MAX_PC);

    state_t            r_state;
    state_t            w_next;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_legal;
    logic              w_uses_mem;
    logic              w_writes_reg;
    logic              w_pc_end;

    insn_class u_insn_class (
        .opcode     (opcode),
        .funct      (funct),
        .legal      (w_legal),
        .uses_mem   (w_uses_mem),
        .writes_reg (w_writes_reg)
    );

    // Unsigned full-width end-of-program test on the post-update pc
    assign w_pc_end = ({1'b0, pc} >= C_MAX_PC);

    // State register; reset drops every state decode immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter and sticky illegal-instruction flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_CHECK) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_EXEC) && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state and datapath enables; acks are only looked at in their own state
    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dec_en   = 1'b0;
        exe_en   = 1'b0;
        pc_we    = 1'b0;
        dmem_req = 1'b0;
        wb_en    = 1'b0;
        out_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we  = 1'b1;
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                dec_en = 1'b1;
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                exe_en = 1'b1;
                pc_we  = w_legal;
                if (!w_legal) begin
                    w_next = ST_HALT;
                end else if (w_uses_mem) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_next = ST_WB;
                end
            end
            ST_WB: begin
                wb_en  = w_writes_reg;
                w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_pc_end) begin
                    out_we = 1'b1;
                    w_next = ST_HALT;
                end else if (step_mode) begin
                    w_next = ST_PAUSE;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    w_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign halted    = (r_state == ST_HALT);
    assign err       = r_err;
    assign instr_cnt = r_cnt;

endmodule : mcycle_ctrl
`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_mcycle_ctrl
//  Brief  : Self-checking bench for mcycle_ctrl. A driver plays both memories
//           and issues random programs; for each instruction it queues the
//           expected per-instruction activity, which a monitor compares
//           against what the controller actually does.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_mcycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [7:0]  pc = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, ir_we, dec_en, exe_en, pc_we, dmem_req;
    logic        wb_en, out_we, busy, halted, err;
    logic [15:0] instr_cnt;

    mcycle_ctrl #(.PC_W(8), .MAX_PC(14), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .opcode(opcode), .funct(funct), .pc(pc),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .dec_en(dec_en), .exe_en(exe_en),
        .pc_we(pc_we), .dmem_req(dmem_req), .wb_en(wb_en), .out_we(out_we),
        .busy(busy), .halted(halted), .err(err), .instr_cnt(instr_cnt)
    );

    initial forever #5 clk = ~clk;

    // Per-instruction activity: cycles spent plus how many cycles each strobe was high
    typedef struct {
        int cyc; int ir; int dec; int exe; int pcwe; int dreq; int wb; int outwe;
        int cnt; int hlt; int bsy; int er;
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL timeout waiting for %s at %0t", nm, $time);
        finish_run();
    endtask

    // ---------------- reference model (instruction-set level) ----------------
    function automatic bit m_legal(input int op, input int fn);
        case (op)
            0:                return (fn == 33) || (fn == 42) || (fn == 8);
            3, 4, 5, 9, 35:   return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic bit m_writes(input int op, input int fn);
        return (op == 0 && (fn == 33 || fn == 42)) || op == 9 || op == 35;
    endfunction

    // ---------------- monitor ----------------
    bit          in_insn = 0;
    logic [15:0] last_cnt = '0;
    bit          last_halted = 0;
    rec_t        acc;

    always @(negedge clk) begin
        if (rst) begin
            in_insn     = 0;
            last_cnt    = '0;
            last_halted = 0;
        end else begin
            if (in_insn && (instr_cnt != last_cnt || (halted && !last_halted))) begin
                rec_t e;
                in_insn = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("cycles",    acc.cyc,   e.cyc);
                    chk("ir_we",     acc.ir,    e.ir);
                    chk("dec_en",    acc.dec,   e.dec);
                    chk("exe_en",    acc.exe,   e.exe);
                    chk("pc_we",     acc.pcwe,  e.pcwe);
                    chk("dmem_req",  acc.dreq,  e.dreq);
                    chk("wb_en",     acc.wb,    e.wb);
                    chk("out_we",    acc.outwe, e.outwe);
                    chk("instr_cnt", int'(instr_cnt), e.cnt);
                    chk("halted",    int'(halted), e.hlt);
                    chk("busy",      int'(busy),   e.bsy);
                    chk("err",       int'(err),    e.er);
                end
            end
            if (!in_insn && imem_req) begin
                in_insn = 1;
                acc = '{default: 0};
            end
            if (in_insn) begin
                acc.cyc++;
                acc.ir    += int'(ir_we);
                acc.dec   += int'(dec_en);
                acc.exe   += int'(exe_en);
                acc.pcwe  += int'(pc_we);
                acc.dreq  += int'(dmem_req);
                acc.wb    += int'(wb_en);
                acc.outwe += int'(out_we);
            end
            last_cnt    = instr_cnt;
            last_halted = halted;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 0; step = 0; imem_ack = 0; dmem_ack = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy",     int'(busy),      0);
        chk("rst_halted",   int'(halted),    0);
        chk("rst_err",      int'(err),       0);
        chk("rst_cnt",      int'(instr_cnt), 0);
        chk("rst_imem_req", int'(imem_req),  0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_imem_req();
        for (int k = 0; k < 40 && !imem_req; k++) tick();
        if (!imem_req) timeout("imem_req");
    endtask

    // Fetch with fd cycles of ack delay; harmless strays are injected meanwhile
    task automatic serve_fetch(input int fd, input int op, input int fn, input int npc);
        wait_imem_req();
        for (int k = 0; k < fd; k++) begin
            dmem_ack = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            step     = 1'($urandom_range(0, 1));
            tick();
        end
        dmem_ack = 0; start = 0; step = 0;
        imem_ack = 1'b1;
        opcode   = 6'(op);
        funct    = 6'(fn);
        pc       = 8'(npc);
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic serve_mem(input int dd);
        for (int k = 0; k < 10 && !dmem_req; k++) tick();
        if (!dmem_req) timeout("dmem_req");
        for (int k = 0; k < dd; k++) begin
            imem_ack = 1'($urandom_range(0, 1));
            tick();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
    endtask

    int ops_l[8] = '{0, 0, 0, 3, 4, 5, 9, 35};
    int fns_l[8] = '{33, 42, 8, 0, 0, 0, 0, 0};
    int ops_i[5] = '{2, 0, 0, 36, 63};
    int fns_i[5] = '{0, 32, 0, 0, 9};
    int pc_end[4] = '{14, 15, 255, 200};

    task automatic run_prog();
        int n   = $urandom_range(1, 6);
        bit sm  = 1'($urandom_range(0, 1));
        int ctr = 0;
        do_reset();
        step_mode = sm;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            bit   last = (i == n - 1);
            int   op, fn, npc, fd, dd, sel;
            bit   lg, lw;
            rec_t e;
            sel = $urandom_range(0, 7);
            op  = ops_l[sel];
            fn  = (op == 0) ? fns_l[sel] : int'($urandom_range(0, 63));
            npc = ($urandom_range(0, 3) == 0) ? 13 : int'($urandom_range(0, 13));
            if (last) begin
                if ($urandom_range(0, 2) == 0) begin
                    sel = $urandom_range(0, 4);
                    op  = ops_i[sel];
                    fn  = fns_i[sel];
                end else begin
                    npc = pc_end[$urandom_range(0, 3)];
                end
            end
            fd = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            dd = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            lg = m_legal(op, fn);
            lw = lg && (op == 35);
            if (lg) ctr++;
            e.cyc   = lg ? (fd + 1) + 1 + 1 + (lw ? dd + 1 : 0) + 1 + 1 : fd + 3;
            e.ir    = 1;
            e.dec   = 1;
            e.exe   = 1;
            e.pcwe  = lg ? 1 : 0;
            e.dreq  = lw ? dd + 1 : 0;
            e.wb    = (lg && m_writes(op, fn)) ? 1 : 0;
            e.outwe = (lg && npc >= 14) ? 1 : 0;
            e.cnt   = ctr;
            e.hlt   = (!lg || npc >= 14) ? 1 : 0;
            e.bsy   = e.hlt ? 0 : 1;
            e.er    = lg ? 0 : 1;
            sb.push_back(e);
            serve_fetch(fd, op, fn, npc);
            if (lw) serve_mem(dd);
            if (!last && sm) begin
                for (int k = 0; k < 10 && int'(instr_cnt) != ctr; k++) tick();
                if (int'(instr_cnt) != ctr) timeout("retire");
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    chk("pause_busy", int'(busy),     1);
                    chk("pause_req",  int'(imem_req), 0);
                    tick();
                end
                if ($urandom_range(0, 3) == 0) begin
                    step_mode = 1'b0;
                    sm = 0;
                    tick();
                end else begin
                    step = 1'b1;
                    tick();
                    step = 1'b0;
                end
            end
        end
        for (int k = 0; k < 20 && !halted; k++) tick();
        if (!halted) timeout("halted");
        pulse_start();
        tick();
        tick();
        chk("halt_ignores_start", int'(halted),   1);
        chk("halt_no_fetch",      int'(imem_req), 0);
        chk("halt_not_busy",      int'(busy),     0);
        chk("queue_drained",      sb.size(),      0);
        sb.delete();
    endtask

    // Asynchronous reset in the middle of a load's memory wait
    task automatic mem_abort();
        do_reset();
        step_mode = 1'b0;
        pulse_start();
        serve_fetch(0, 35, 0, 3);
        for (int k = 0; k < 10 && !dmem_req; k++) tick();
        if (!dmem_req) timeout("dmem_req");
        tick();
        chk("abort_pre_dmem_req", int'(dmem_req), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_dmem_req", int'(dmem_req), 0);
        chk("abort_busy",     int'(busy),     0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_idle_req", int'(imem_req),  0);
        chk("abort_idle_cnt", int'(instr_cnt), 0);
        chk("abort_idle_hlt", int'(halted),    0);
    endtask

    initial begin
        for (int r = 0; r < 30; r++) run_prog();
        mem_abort();
        finish_run();
    end

    // Absolute guard against a stalled run
    initial begin
        #400000;
        timeout("global_limit");
    end

endmodule : tb_mcycle_ctrl
`default_nettype wire
